// File: rtl/cursor_motion_if.sv
// Button/strobe inputs and cursor outputs of the cursor motion controller.
// master drives buttons and strobes; slave is the controller.
interface cursor_motion_if;
  logic        enable;
  logic        tick;
  logic        recenter;
  logic        btnL;
  logic        btnR;
  logic        btnU;
  logic        btnD;
  logic        btnC;
  logic [11:0] cursor_x;
  logic [11:0] cursor_y;
  logic [5:0]  speed;
  logic        moving;
  logic        click_pulse;

  modport master (
    output enable, tick, recenter,
    output btnL, btnR, btnU, btnD, btnC,
    input  cursor_x, cursor_y, speed,
    input  moving, click_pulse
  );

  modport slave (
    input  enable, tick, recenter,
    input  btnL, btnR, btnU, btnD, btnC,
    output cursor_x, cursor_y, speed,
    output moving, click_pulse
  );
endinterface

// File: rtl/cursor_motion_ctrl.sv
// Cursor position sequencer: step on press, repeat, then accelerate,
// clamped to the frame; plus a one-shot click strobe from btnC.
module cursor_motion_ctrl #(
  parameter int H_MAX      = 1279,
  parameter int V_MAX      = 1023,
  parameter int H_INIT     = 640,
  parameter int V_INIT     = 512,
  parameter int REPEAT_DLY = 3,
  parameter int SPEED_MAX  = 63
) (
  input logic             clk,
  input logic             rst,
  cursor_motion_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_ACCEL = 2'd2;

  localparam logic [1:0] D_L = 2'd0;
  localparam logic [1:0] D_R = 2'd1;
  localparam logic [1:0] D_U = 2'd2;
  localparam logic [1:0] D_D = 2'd3;

  localparam logic        [7:0]  RPT    = 8'(REPEAT_DLY);
  localparam logic        [5:0]  SMAX   = 6'(SPEED_MAX);
  localparam logic signed [12:0] HMAX_S = 13'(H_MAX);
  localparam logic signed [12:0] VMAX_S = 13'(V_MAX);
  localparam logic        [11:0] HMAX_U = 12'(H_MAX);
  localparam logic        [11:0] VMAX_U = 12'(V_MAX);
  localparam logic        [11:0] HINIT  = 12'(H_INIT);
  localparam logic        [11:0] VINIT  = 12'(V_INIT);

  logic [1:0]  state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [7:0]  hold_q, hold_d;
  logic [5:0]  speed_q, speed_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        btnc_q, btnc_d;
  logic        click_q, click_d;

  logic        dir_any;
  logic        dir_valid;
  logic [1:0]  dir_now;
  logic        fresh;
  logic        do_step;
  logic signed [12:0] step;
  logic signed [12:0] xs, ys;
  logic signed [12:0] x_dec, x_inc;
  logic signed [12:0] y_dec, y_inc;

  // Decode a single direction button; btnC or multiple buttons mean none
  always_comb begin
    dir_now   = D_L;
    dir_valid = 1'b0;
    dir_any   = bus.btnL | bus.btnR | bus.btnU | bus.btnD;
    case ({bus.btnL, bus.btnR, bus.btnU, bus.btnD})
      4'b1000: begin dir_now = D_L; dir_valid = ~bus.btnC; end
      4'b0100: begin dir_now = D_R; dir_valid = ~bus.btnC; end
      4'b0010: begin dir_now = D_U; dir_valid = ~bus.btnC; end
      4'b0001: begin dir_now = D_D; dir_valid = ~bus.btnC; end
      default: ;
    endcase
  end

  // Motion FSM: decides step size and the repeat/acceleration state
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    speed_d = speed_q;
    do_step = 1'b0;
    step    = 13'sd1;
    fresh   = 1'b0;
    unique case (state_q)
      S_IDLE: fresh = bus.enable & bus.tick & dir_valid;
      S_HOLD, S_ACCEL: begin
        if (!dir_valid || !bus.enable) begin
          state_d = S_IDLE;
          hold_d  = '0;
          speed_d = '0;
        end else if (bus.tick) begin
          if (dir_now != dir_q) begin
            fresh = 1'b1;
          end else if (state_q == S_HOLD) begin
            do_step = 1'b1;
            hold_d  = hold_q + 8'd1;
            if (hold_d == RPT) begin
              state_d = S_ACCEL;
              speed_d = '0;
            end
          end else begin
            do_step = 1'b1;
            step    = 13'sd1 + $signed({7'd0, speed_q});
            if (speed_q != SMAX) speed_d = speed_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
        speed_d = '0;
      end
    endcase
    if (fresh) begin
      do_step = 1'b1;
      step    = 13'sd1;
      dir_d   = dir_now;
      hold_d  = 8'd1;
      speed_d = '0;
      state_d = (RPT == 8'd1) ? S_ACCEL : S_HOLD;
    end
  end

  // Clamped position update; recenter overrides any step
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    xs    = $signed({1'b0, x_q});
    ys    = $signed({1'b0, y_q});
    x_dec = xs - step;
    x_inc = xs + step;
    y_dec = ys - step;
    y_inc = ys + step;
    if (bus.recenter) begin
      x_d = HINIT;
      y_d = VINIT;
    end else if (do_step) begin
      unique case (dir_now)
        D_L: x_d = x_dec[12] ? 12'd0 : x_dec[11:0];
        D_R: x_d = (x_inc > HMAX_S) ? HMAX_U : x_inc[11:0];
        D_U: y_d = y_dec[12] ? 12'd0 : y_dec[11:0];
        D_D: y_d = (y_inc > VMAX_S) ? VMAX_U : y_inc[11:0];
      endcase
    end
  end

  // Rising-edge detect on btnC, qualified by enable and no direction
  always_comb begin
    btnc_d  = bus.btnC;
    click_d = bus.btnC & ~btnc_q & bus.enable & ~dir_any;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= D_L;
      hold_q  <= '0;
      speed_q <= '0;
      x_q     <= HINIT;
      y_q     <= VINIT;
      btnc_q  <= 1'b0;
      click_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      speed_q <= speed_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btnc_q  <= btnc_d;
      click_q <= click_d;
    end
  end

  assign bus.cursor_x    = x_q;
  assign bus.cursor_y    = y_q;
  assign bus.speed       = speed_q;
  assign bus.moving      = (state_q != S_IDLE);
  assign bus.click_pulse = click_q;

endmodule

// File: tb/tb_cursor_motion_ctrl.sv
// Bench for cursor_motion_ctrl: run-length reference model checked every
// cycle, plus hand-computed literal checks of the key scenarios.
module tb_cursor_motion_ctrl;

  localparam int RD   = 3;
  localparam int SMAX = 63;

  logic clk;
  logic rst;
  logic clk_run;
  logic chk_on;

  int vectors;
  int miscompares;
  int pcount;

  cursor_motion_if bus ();

  cursor_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 if (clk_run) clk = ~clk;

  // Reference model: the motion is described by the length of the current
  // run of same-direction ticks, not by any state machine.
  int mx, my, run, mdir, mspeed;
  bit mmoving, mclick, mprevc;

  function automatic int dir_of(bit l, bit r, bit u, bit d);
    if ({l, r, u, d} == 4'b1000) return 0;
    if ({l, r, u, d} == 4'b0100) return 1;
    if ({l, r, u, d} == 4'b0010) return 2;
    if ({l, r, u, d} == 4'b0001) return 3;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int d, st, nx, ny;
    if (rst) begin
      mx = 640; my = 512; run = 0; mdir = 0;
      mclick = 0; mprevc = 0;
    end else begin
      d = dir_of(bus.btnL, bus.btnR, bus.btnU, bus.btnD);
      if (bus.btnC) d = -1;
      mclick = bus.btnC && !mprevc && bus.enable &&
               !(bus.btnL || bus.btnR || bus.btnU || bus.btnD);
      mprevc = bus.btnC;
      nx = mx; ny = my;
      if (!bus.enable || d < 0) begin
        run = 0;
      end else if (bus.tick) begin
        if (run > 0 && d == mdir) run++;
        else begin run = 1; mdir = d; end
        if (run <= RD) st = 1;
        else st = 1 + ((run - 1 - RD) < SMAX ? (run - 1 - RD) : SMAX);
        case (d)
          0: nx = (mx - st < 0) ? 0 : mx - st;
          1: nx = (mx + st > 1279) ? 1279 : mx + st;
          2: ny = (my - st < 0) ? 0 : my - st;
          default: ny = (my + st > 1023) ? 1023 : my + st;
        endcase
      end
      if (bus.recenter) begin nx = 640; ny = 512; end
      mx = nx; my = ny;
    end
    mmoving = run > 0;
    if (run >= RD) mspeed = (run - RD) < SMAX ? (run - RD) : SMAX;
    else mspeed = 0;
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (bus.cursor_x != 12'(mx) || bus.cursor_y != 12'(my) ||
          bus.speed != 6'(mspeed) || bus.moving != mmoving ||
          bus.click_pulse != mclick) begin
        miscompares++;
        $display("FAIL model t=%0t x=%0d/%0d y=%0d/%0d spd=%0d/%0d mv=%0b/%0b clk=%0b/%0b",
          $time, bus.cursor_x, mx, bus.cursor_y, my, bus.speed, mspeed,
          bus.moving, mmoving, bus.click_pulse, mclick);
      end
    end
  end

  always @(negedge clk) if (bus.click_pulse) pcount++;

  task automatic chk(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick1();
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    cyc(2);
  endtask

  task automatic ticks(int n);
    repeat (n) tick1();
  endtask

  task automatic release_all();
    @(negedge clk);
    bus.btnL = 0; bus.btnR = 0; bus.btnU = 0; bus.btnD = 0; bus.btnC = 0;
    cyc(2);
  endtask

  int t2x[6] = '{641, 642, 643, 644, 646, 649};
  int t3x[6] = '{1, 0, 0, 0, 0, 0};

  initial begin
    vectors = 0; miscompares = 0; pcount = 0;
    clk = 0; clk_run = 0; chk_on = 0; rst = 0;
    bus.enable = 0; bus.tick = 0; bus.recenter = 0;
    bus.btnL = 0; bus.btnR = 0; bus.btnU = 0; bus.btnD = 0; bus.btnC = 0;

    // T1: reset with no clock edge
    #2 rst = 1;
    #1 chk("rst_x", int'(bus.cursor_x), 640);
    chk("rst_y", int'(bus.cursor_y), 512);
    chk("rst_speed", int'(bus.speed), 0);
    chk("rst_moving", int'(bus.moving), 0);
    chk("rst_click", int'(bus.click_pulse), 0);
    #1 rst = 0;
    #2 clk_run = 1;
    bus.enable = 1;
    cyc(2);
    chk_on = 1;

    // T2: hold right, repeat then accelerate
    @(negedge clk); bus.btnR = 1;
    for (int i = 0; i < 6; i++) begin
      tick1();
      chk($sformatf("t2_x%0d", i + 1), int'(bus.cursor_x), t2x[i]);
    end
    chk("t2_speed", int'(bus.speed), 3);
    chk("t2_moving", int'(bus.moving), 1);
    @(negedge clk); bus.btnR = 0;
    @(negedge clk);
    chk("t2_rel_moving", int'(bus.moving), 0);
    chk("t2_rel_speed", int'(bus.speed), 0);

    // T3: clamp at left edge, then bottom edge
    @(negedge clk); bus.btnL = 1;
    ticks(45);
    chk("t3_x_floor", int'(bus.cursor_x), 0);
    release_all();
    @(negedge clk); bus.btnR = 1;
    ticks(2);
    release_all();
    chk("t3_x2", int'(bus.cursor_x), 2);
    @(negedge clk); bus.btnL = 1;
    for (int i = 0; i < 6; i++) begin
      tick1();
      chk($sformatf("t3_xl%0d", i + 1), int'(bus.cursor_x), t3x[i]);
    end
    release_all();
    @(negedge clk); bus.btnD = 1;
    ticks(45);
    chk("t3_y_max", int'(bus.cursor_y), 1023);
    release_all();
    @(negedge clk); bus.btnU = 1;
    tick1();
    release_all();
    chk("t3_y1022", int'(bus.cursor_y), 1022);
    @(negedge clk); bus.btnD = 1;
    for (int i = 0; i < 3; i++) begin
      tick1();
      chk($sformatf("t3_yd%0d", i + 1), int'(bus.cursor_y), 1023);
    end
    release_all();

    // T4: diagonal gives no motion; direction switch restarts at step 1
    @(negedge clk); bus.btnL = 1; bus.btnU = 1;
    ticks(5);
    chk("t4_diag_x", int'(bus.cursor_x), 0);
    chk("t4_diag_y", int'(bus.cursor_y), 1023);
    chk("t4_diag_moving", int'(bus.moving), 0);
    release_all();
    @(negedge clk); bus.btnR = 1;
    ticks(6);
    chk("t4_r_x", int'(bus.cursor_x), 9);
    chk("t4_r_speed", int'(bus.speed), 3);
    @(negedge clk); bus.btnR = 0; bus.btnU = 1;
    tick1();
    chk("t4_u_y", int'(bus.cursor_y), 1022);
    chk("t4_u_x", int'(bus.cursor_x), 9);
    chk("t4_u_speed", int'(bus.speed), 0);
    release_all();

    // T5: click strobe
    pcount = 0;
    @(negedge clk); bus.btnC = 1;
    cyc(100);
    bus.btnC = 0;
    cyc(3);
    chk("t5_click_held", pcount, 1);
    pcount = 0;
    @(negedge clk); bus.btnR = 1;
    @(negedge clk); bus.btnC = 1;
    cyc(10);
    release_all();
    chk("t5_click_dir", pcount, 0);
    pcount = 0;
    @(negedge clk); bus.enable = 0; bus.btnC = 1;
    cyc(10);
    bus.btnC = 0;
    @(negedge clk); bus.btnR = 1;
    ticks(2);
    chk("t5_dis_x", int'(bus.cursor_x), 9);
    release_all();
    bus.enable = 1;
    cyc(3);
    chk("t5_click_dis", pcount, 0);

    // T6: async reset mid-acceleration, then recenter beats a tick
    @(negedge clk); bus.btnR = 1;
    ticks(8);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("t6_rst_x", int'(bus.cursor_x), 640);
    chk("t6_rst_moving", int'(bus.moving), 0);
    chk("t6_rst_speed", int'(bus.speed), 0);
    #1 rst = 0;
    ticks(2);
    chk("t6_x642", int'(bus.cursor_x), 642);
    @(negedge clk); bus.tick = 1; bus.recenter = 1;
    @(negedge clk); bus.tick = 0; bus.recenter = 0;
    chk("t6_recenter_x", int'(bus.cursor_x), 640);
    chk("t6_recenter_moving", int'(bus.moving), 1);
    release_all();

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
